// File: rtl/tl_ul_arbiter.sv
// Two-master, one-slave TileLink-UL arbiter with round-robin grant, one transaction
// in flight, and a watchdog that answers with an error when the slave goes silent.
module tl_ul_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int MASK_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [ADDR_W-1:0] m0_a_address,
  input  logic [DATA_W-1:0] m0_a_data,
  input  logic [1:0]        m0_a_size,
  input  logic [MASK_W-1:0] m0_a_mask,
  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [DATA_W-1:0] m0_d_data,
  output logic              m0_d_error,
  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [ADDR_W-1:0] m1_a_address,
  input  logic [DATA_W-1:0] m1_a_data,
  input  logic [1:0]        m1_a_size,
  input  logic [MASK_W-1:0] m1_a_mask,
  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [DATA_W-1:0] m1_d_data,
  output logic              m1_d_error,
  output logic              s_a_valid,
  input  logic              s_a_ready,
  output logic [2:0]        s_a_opcode,
  output logic [ADDR_W-1:0] s_a_address,
  output logic [DATA_W-1:0] s_a_data,
  output logic [1:0]        s_a_size,
  output logic [MASK_W-1:0] s_a_mask,
  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [2:0]        s_d_opcode,
  input  logic [DATA_W-1:0] s_d_data
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT_D, ERR} state_t;

  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state, state_nxt;
  logic                grant, grant_nxt;
  logic                last, last_nxt;
  logic                op_get, op_get_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;

  logic                a_ready_g, d_valid_g, d_error, mg_d_ready;
  logic [2:0]          d_opcode;
  logic [DATA_W-1:0]   d_data;

  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign mg_d_ready  = grant ? m1_d_ready   : m0_d_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      op_get <= 1'b0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      last   <= last_nxt;
      op_get <= op_get_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last;
    op_get_nxt = op_get;
    timer_nxt  = timer;
    s_a_valid  = 1'b0;
    s_d_ready  = 1'b0;
    a_ready_g  = 1'b0;
    d_valid_g  = 1'b0;
    d_error    = 1'b0;
    d_opcode   = s_d_opcode;
    d_data     = s_d_data;
    case (state)
      IDLE: begin
        // Draining the slave here discards responses that arrive after a timeout.
        // Held low while reset is asserted so every handshake output is quiet.
        s_d_ready = reset;
        if (m0_a_valid || m1_a_valid) begin
          grant_nxt = (m0_a_valid && m1_a_valid) ? ~last : m1_a_valid;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_a_valid = 1'b1;
        a_ready_g = s_a_ready;
        if (s_a_ready) begin
          op_get_nxt = (s_a_opcode == 3'd4);
          timer_nxt  = '0;
          state_nxt  = WAIT_D;
        end
      end
      WAIT_D: begin
        d_valid_g = s_d_valid;
        s_d_ready = mg_d_ready;
        if (s_d_valid && mg_d_ready) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end else if (!s_d_valid && (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST)) begin
          // A response already presented but stalled by the master is never overridden.
          state_nxt = ERR;
        end else if (timer != '1) begin
          timer_nxt = timer + 1'b1;
        end
      end
      ERR: begin
        d_valid_g = 1'b1;
        d_error   = 1'b1;
        d_data    = '0;
        d_opcode  = {2'b00, op_get};
        s_d_ready = 1'b1;
        if (mg_d_ready) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_a_ready  = a_ready_g & ~grant;
  assign m1_a_ready  = a_ready_g &  grant;
  assign m0_d_valid  = d_valid_g & ~grant;
  assign m1_d_valid  = d_valid_g &  grant;
  assign m0_d_opcode = d_opcode;
  assign m1_d_opcode = d_opcode;
  assign m0_d_data   = d_data;
  assign m1_d_data   = d_data;
  assign m0_d_error  = d_error;
  assign m1_d_error  = d_error;

endmodule
